te_frame_ctrl: RTL

TE_FRAME_CTRL -- requirements
Module: te_frame_ctrl

---
 rtl/te_frame_ctrl_if.sv | 38 +++
 rtl/te_frame_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/te_frame_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | te_frame_ctrl_if : control/handshake bundle between te_frame_ctrl, the     |
// |                    window source and the transmission estimator.           |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
interface te_frame_ctrl_if #(
    parameter int CW = 10
) ();
    logic          start;
    logic          abort;
    logic          atm_valid;
    logic          win_valid;
    logic          win_ready;
    logic          te_in_valid;
    logic          te_atm_valid;
    logic          te_clr;
    logic          trans_valid;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic          busy;
    logic          frame_done;

    // Controller side
    modport master (
        input  start, abort, atm_valid, win_valid,
        output win_ready, te_in_valid, te_atm_valid, te_clr, trans_valid,
        output col, row, busy, frame_done
    );

    // Environment side
    modport slave (
        output start, abort, atm_valid, win_valid,
        input  win_ready, te_in_valid, te_atm_valid, te_clr, trans_valid,
        input  col, row, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/te_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | te_frame_ctrl : frame sequencer for the transmission estimator; gates      |
// |                 3x3 windows, tracks col/row and drains estimator results.  |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module te_frame_ctrl #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int PIPE_LAT = 4,
    parameter int CW       = 10
) (
    input  wire logic      clk,
    input  wire logic      rst,
    te_frame_ctrl_if.master bus
);

    localparam int              c_TOTAL    = IMG_W * IMG_H;
    localparam int              c_OCW      = $clog2(c_TOTAL + 1);
    localparam logic [CW-1:0]   c_COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0]   c_ROW_LAST = CW'(IMG_H - 1);
    localparam logic [c_OCW-1:0] c_OUT_LAST = c_OCW'(c_TOTAL - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_WAIT_ATM = 3'd2,
        S_RUN      = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CW-1:0]       r_col;
    logic [CW-1:0]       r_row;
    logic [c_OCW-1:0]    r_out_cnt;
    logic [PIPE_LAT-1:0] r_pipe;
    logic                r_atm_ok;

    logic w_kill;
    logic w_win_ready;
    logic w_te_clr;
    logic w_busy;
    logic w_frame_done;
    logic w_accept;
    logic w_last_accept;
    logic w_trans_valid;
    logic w_out_last;

    assign w_kill        = bus.abort && (r_state != S_IDLE);
    assign w_accept      = bus.win_valid && w_win_ready;
    assign w_last_accept = w_accept && (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
    assign w_trans_valid = r_pipe[PIPE_LAT-1];
    assign w_out_last    = w_trans_valid && (r_out_cnt == c_OUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_win_ready  = 1'b0;
        w_te_clr     = 1'b0;
        w_frame_done = 1'b0;
        w_busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_te_clr = 1'b1;
                w_next   = S_WAIT_ATM;
            end
            S_WAIT_ATM: begin
                if (r_atm_ok || bus.atm_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                w_win_ready = 1'b1;
                if (w_last_accept) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_out_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_frame_done = 1'b1;
                w_next       = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Abort outranks every other transition, including DONE->IDLE
        if (w_kill) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_kill) begin
            r_col     <= '0;
            r_row     <= '0;
            r_out_cnt <= '0;
            r_atm_ok  <= 1'b0;
        end else if (r_state == S_CLEAR) begin
            r_col     <= '0;
            r_row     <= '0;
            r_out_cnt <= '0;
            r_atm_ok  <= bus.atm_valid;
        end else begin
            if (bus.atm_valid && (r_state != S_IDLE)) begin
                r_atm_ok <= 1'b1;
            end
            if (w_accept) begin
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            if (w_trans_valid) begin
                r_out_cnt <= r_out_cnt + 1'b1;
            end
        end
    end

    // Mirror of the estimator latency; keeps shifting through input gaps
    generate
        if (PIPE_LAT == 1) begin : g_pipe_one
            always_ff @(posedge clk) begin
                if (rst || w_kill) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= w_accept;
                end
            end
        end else begin : g_pipe_multi
            always_ff @(posedge clk) begin
                if (rst || w_kill) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[PIPE_LAT-2:0], w_accept};
                end
            end
        end
    endgenerate

    assign bus.win_ready    = w_win_ready;
    assign bus.te_in_valid  = w_accept;
    assign bus.te_atm_valid = r_atm_ok;
    assign bus.te_clr       = w_te_clr;
    assign bus.trans_valid  = w_trans_valid;
    assign bus.col          = r_col;
    assign bus.row          = r_row;
    assign bus.busy         = w_busy;
    assign bus.frame_done   = w_frame_done;

endmodule
`default_nettype wire
